freq_meter: RTL and testbench

Gated-window frequency meter in the `clk_in` domain. It synchronises an asynchronous square-wave input and counts its rising edges over a fixed gate window of `F_IN/GATE_HZ` cycles. It reports the count with a one-cycle valid strobe. It is the measuring end of the clock-division path: it checks divided clocks and external signals on the board and feeds the count to the display/readout logic.

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 35 +++
 rtl/freq_meter.sv | 140 ++++++++++++++
 tb/tb_freq_meter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and gate-window sizing helper for the
// gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Number of clk_in cycles in one gate window.
  function automatic int gate_cycles(input int f_in, input int gate_hz);
    return f_in / gate_hz;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser for an asynchronous input followed
// by an edge register; emits a one-cycle pulse per synchronised rising edge.
module sync_edge_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_in,
  output logic rise_pulse
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next-state of the synchroniser chain and edge register.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser and edge-register flops, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// window of F_IN/GATE_HZ clk_in cycles and reports the result with a strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int F_IN    = 100_000_000,
  parameter int GATE_HZ = 1,
  parameter int COUNT_W = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic [COUNT_W-1:0] count_out,
  output logic               valid,
  output logic               overflow
);

  localparam int GC  = gate_cycles(F_IN, GATE_HZ);
  localparam int GCW = $clog2(GC);
  localparam logic [GCW-1:0]     GATE_LAST = GCW'(GC - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

  logic rise_pulse;

  sync_edge_detect u_sync (
    .clk_in     (clk_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .rise_pulse (rise_pulse)
  );

  state_e             state_q, state_d;
  logic [GCW-1:0]     gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  // Edge count and saturation flag including the edge seen this cycle.
  logic [COUNT_W-1:0] cnt_next;
  logic               sat_next;

  // Saturating increment of the edge counter.
  always_comb begin
    cnt_next = edge_cnt_q;
    sat_next = sat_q;
    if (rise_pulse) begin
      if (edge_cnt_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = edge_cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_next = edge_cnt_q;
    end
  end

  // Window sequencing: gate counter, result latching and mode handling.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (start | continuous) begin
          state_d    = MEASURE;
          busy_d     = 1'b1;
          gate_cnt_d = {GCW{1'b0}};
          edge_cnt_d = {COUNT_W{1'b0}};
          sat_d      = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      MEASURE: begin
        if (gate_cnt_q == GATE_LAST) begin
          count_d    = cnt_next;
          ovf_d      = sat_next;
          valid_d    = 1'b1;
          gate_cnt_d = {GCW{1'b0}};
          edge_cnt_d = {COUNT_W{1'b0}};
          sat_d      = 1'b0;
          if (continuous) begin
            busy_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gate_cnt_d = gate_cnt_q + {{(GCW-1){1'b0}}, 1'b1};
          edge_cnt_d = cnt_next;
          sat_d      = sat_next;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      gate_cnt_q <= {GCW{1'b0}};
      edge_cnt_q <= {COUNT_W{1'b0}};
      sat_q      <= 1'b0;
      count_q    <= {COUNT_W{1'b0}};
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign count_out = count_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: reference-model bench for freq_meter with a 32-bit and a
// 2-bit count instance driven by the same stimulus.
module tb_freq_meter;

  localparam int F_IN    = 100;
  localparam int GATE_HZ = 10;
  localparam int GC      = 10;

  logic        clk_in = 1'b0;
  logic        reset, sig_in, start, continuous;
  logic        busy_a, valid_a, ovf_a;
  logic [31:0] cnt_a;
  logic        busy_b, valid_b, ovf_b;
  logic [1:0]  cnt_b;

  freq_meter #(.F_IN(F_IN), .GATE_HZ(GATE_HZ), .COUNT_W(32)) dut (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy_a), .count_out(cnt_a),
    .valid(valid_a), .overflow(ovf_a)
  );

  freq_meter #(.F_IN(F_IN), .GATE_HZ(GATE_HZ), .COUNT_W(2)) dut_ov (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy_b), .count_out(cnt_b),
    .valid(valid_b), .overflow(ovf_b)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d at cycle", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sampled history of sig_in: a rise between the samples taken two and three
  // clocks ago is what the meter counts this clock.
  int     cyc = 0;
  bit     h1, h2, h3;
  bit     m_busy, m_valid;
  int     win_pos;
  longint raw;
  longint m_cnt_a, m_cnt_b;
  bit     m_ovf_a, m_ovf_b;
  bit     cmp_en = 1'b0;

  task automatic model_step();
    bit e;
    cyc = cyc + 1;
    if (reset) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_busy = 0; m_valid = 0; win_pos = 0; raw = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
    end else begin
      e = h2 & ~h3;
      m_valid = 0;
      if (!m_busy) begin
        if (start || continuous) begin
          m_busy = 1; win_pos = 0; raw = 0;
        end
      end else begin
        raw = raw + longint'(e);
        if (win_pos == GC - 1) begin
          m_valid = 1;
          m_cnt_a = (raw > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : raw;
          m_ovf_a = (raw > 64'hFFFF_FFFF);
          m_cnt_b = (raw > 3) ? 3 : raw;
          m_ovf_b = (raw > 3);
          win_pos = 0; raw = 0;
          if (!continuous) m_busy = 0;
        end else begin
          win_pos = win_pos + 1;
        end
      end
      h3 = h2; h2 = h1; h1 = sig_in;
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk_in);
    if (cmp_en) begin
      chk("busy_a",  64'(busy_a),  64'(m_busy));
      chk("valid_a", 64'(valid_a), 64'(m_valid));
      chk("count_a", 64'(cnt_a),   m_cnt_a);
      chk("ovf_a",   64'(ovf_a),   64'(m_ovf_a));
      chk("busy_b",  64'(busy_b),  64'(m_busy));
      chk("valid_b", 64'(valid_b), 64'(m_valid));
      chk("count_b", 64'(cnt_b),   m_cnt_b);
      chk("ovf_b",   64'(ovf_b),   64'(m_ovf_b));
    end
  end

  // Strobe monitor used by the directed literal checks.
  int          n_valid = 0;
  int          last_valid_cyc = 0, prev_valid_cyc = 0;
  logic [31:0] last_cnt_a;
  logic [1:0]  last_cnt_b;
  logic        last_ovf_b;

  initial forever begin
    @(negedge clk_in);
    if (valid_a === 1'b1) begin
      n_valid        = n_valid + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      last_cnt_a     = cnt_a;
      last_cnt_b     = cnt_b;
      last_ovf_b     = ovf_b;
    end
  end

  // ---------------- stimulus ----------------
  int mode = 0;   // 0 hold, 1 toggle every cycle, 2 period-10 divider, 3 random
  int div_cnt = 0;

  task automatic tick();
    @(negedge clk_in);
    #1;
    case (mode)
      1: sig_in = ~sig_in;
      2: begin
        div_cnt = div_cnt + 1;
        if (div_cnt == 5) begin
          div_cnt = 0;
          sig_in  = ~sig_in;
        end
      end
      3: sig_in = 1'($urandom_range(0, 1));
      default: sig_in = sig_in;
    endcase
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int v0, s_cyc;
  bit seen;

  initial begin
    reset = 1'b1; sig_in = 1'b0; start = 1'b0; continuous = 1'b0;
    tick();
    cmp_en = 1'b1;
    ticks(2);
    reset = 1'b0;

    // Idle after reset: nothing happens.
    ticks(20);
    chk("idle_nvalid", 64'(n_valid), 64'd0);
    chk("idle_busy",   64'(busy_a),  64'd0);
    chk("idle_count",  64'(cnt_a),   64'd0);
    chk("idle_ovf",    64'(ovf_a),   64'd0);

    // One-shot with sig_in toggling every cycle: 5 rises per window.
    mode = 1;
    ticks(4);
    v0 = n_valid;
    start = 1'b1; s_cyc = cyc + 1;
    tick();
    start = 1'b0;
    chk("oneshot_busy_next", 64'(busy_a), 64'd1);
    ticks(12);
    chk("oneshot_nvalid",  64'(n_valid - v0), 64'd1);
    chk("oneshot_latency", 64'(last_valid_cyc - s_cyc), 64'd10);
    chk("oneshot_count",   64'(last_cnt_a), 64'd5);
    chk("oneshot_busy_end", 64'(busy_a), 64'd0);
    chk("sat_count_b", 64'(last_cnt_b), 64'd3);
    chk("sat_ovf_b",   64'(last_ovf_b), 64'd1);

    // Quiet window clears the saturated result.
    mode = 0; sig_in = 1'b0;
    ticks(5);
    start = 1'b1; tick(); start = 1'b0;
    ticks(12);
    chk("quiet_count_b", 64'(last_cnt_b), 64'd0);
    chk("quiet_ovf_b",   64'(last_ovf_b), 64'd0);
    chk("quiet_count_a", 64'(last_cnt_a), 64'd0);

    // Start pulsed during a window is ignored.
    v0 = n_valid;
    start = 1'b1; tick(); start = 1'b0;
    ticks(3);
    start = 1'b1; tick(); start = 1'b0;
    ticks(15);
    chk("midstart_nvalid", 64'(n_valid - v0), 64'd1);
    chk("midstart_busy",   64'(busy_a), 64'd0);

    // Continuous mode with a period-10 divided clock: one rise per window.
    mode = 2; div_cnt = 0;
    v0 = n_valid;
    continuous = 1'b1;
    ticks(55);
    chk("cont_nvalid_ge4", 64'(n_valid - v0 >= 4), 64'd1);
    chk("cont_spacing",    64'(last_valid_cyc - prev_valid_cyc), 64'd10);
    chk("cont_count",      64'(last_cnt_a), 64'd1);
    chk("cont_busy",       64'(busy_a), 64'd1);

    // Drop continuous mid-window: that window finishes, then idle.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (valid_a === 1'b1) seen = 1'b1;
    end
    chk("cont_sync_found", 64'(seen), 64'd1);
    ticks(4);
    continuous = 1'b0;
    v0 = n_valid;
    ticks(15);
    chk("drop_nvalid", 64'(n_valid - v0), 64'd1);
    chk("drop_busy",   64'(busy_a), 64'd0);

    // Reset in the middle of a window aborts it.
    mode = 1;
    v0 = n_valid;
    start = 1'b1; tick(); start = 1'b0;
    ticks(5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_busy",  64'(busy_a), 64'd0);
    chk("rst_count", 64'(cnt_a),  64'd0);
    chk("rst_ovf",   64'(ovf_a),  64'd0);
    ticks(15);
    chk("rst_nvalid", 64'(n_valid - v0), 64'd0);

    // Randomised traffic checked against the model every cycle.
    mode = 3;
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    start = 1'b0; continuous = 1'b0; reset = 1'b0;
    ticks(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
